// File: rtl/histogram_hesaplayici.sv
// histogram_hesaplayici
//   Per-frame pixel histogram engine. Each accepted pixel is binned by its top BIN_BIT bits
//   and counted in an internal RAM through a two-stage read-modify-write pipeline that
//   forwards the in-flight write, so back-to-back pixels of the same bin count exactly.
//   After KARE_PIKSEL accepted pixels the pipeline drains and the bins become readable.
//   Counters saturate at 2^SAYAC_BIT-1 and raise the sticky tasma_o flag.
//
//   Optional feature macro: HISTOGRAM_CDF_EN
//     defined   : after the drain, bins are rewritten in place with their cumulative sum
//                 (saturating), taking 2^BIN_BIT+1 busy cycles before hazir_o rises.
//     undefined : no cumulative pass; reads return raw per-bin counts.
//
// Ports
//   clk_i         clock, all logic on posedge
//   rstn_i        synchronous active-low reset
//   etkin_i       pixel_i valid this cycle
//   pixel_i       input pixel
//   temizle_i     one-cycle pulse: clear RAM, abort and restart the frame
//   mesgul_o      clearing or cumulative pass in progress; pixels dropped
//   hazir_o       frame histogram complete and readable
//   oku_i         bin read request, honoured only while hazir_o=1
//   oku_adres_i   bin index to read
//   oku_gecerli_o oku_veri_o valid (one cycle after oku_i)
//   oku_veri_o    bin count; holds its value when no read is issued
//   tasma_o       sticky: a counter saturated this frame
module histogram_hesaplayici #(
   parameter int unsigned PIXEL_BIT   = 8,
   parameter int unsigned BIN_BIT     = 8,
   parameter int unsigned SAYAC_BIT   = 17,
   parameter int unsigned KARE_PIKSEL = 76800
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 etkin_i,
   input  logic [PIXEL_BIT-1:0] pixel_i,
   input  logic                 temizle_i,
   output logic                 mesgul_o,
   output logic                 hazir_o,
   input  logic                 oku_i,
   input  logic [BIN_BIT-1:0]   oku_adres_i,
   output logic                 oku_gecerli_o,
   output logic [SAYAC_BIT-1:0] oku_veri_o,
   output logic                 tasma_o
);

   localparam int unsigned BinSayisi = 2 ** BIN_BIT;
   localparam int unsigned PsayBit   = $clog2(KARE_PIKSEL + 1);
   localparam logic [SAYAC_BIT-1:0] SayacMax  = '1;
   localparam logic [PsayBit-1:0]   SonPiksel = PsayBit'(KARE_PIKSEL - 1);

`ifdef HISTOGRAM_CDF_EN
   typedef enum logic [2:0] {StTemizle, StTopla, StBosalt, StKumulatif, StBitti} durum_e;
`else
   typedef enum logic [1:0] {StTemizle, StTopla, StBosalt, StBitti} durum_e;
`endif

   durum_e               durum_q;
   // Shared walk address for clearing and the cumulative pass; the extra MSB marks the
   // final cycle of the cumulative pass.
   logic [BIN_BIT:0]     adres_q;
   logic [PsayBit-1:0]   psay_q;
   logic [1:0]           bosalt_q;

   logic                 s0_gecerli_q;
   logic [BIN_BIT-1:0]   s0_bin_q;
   logic                 s1_gecerli_q;
   logic [BIN_BIT-1:0]   s1_bin_q;
   logic [SAYAC_BIT-1:0] s1_deger_q;

   logic [SAYAC_BIT-1:0] bellek_q [BinSayisi];

   logic [BIN_BIT-1:0]   pixel_bin;
   logic                 kabul;
   logic [BIN_BIT-1:0]   rmw_adres;
   logic [SAYAC_BIT-1:0] rmw_okunan;
   logic [SAYAC_BIT-1:0] s0_eski;
   logic                 s0_doygun;
   logic [SAYAC_BIT-1:0] s0_yeni;
   logic                 yaz;
   logic [BIN_BIT-1:0]   yaz_adres;
   logic [SAYAC_BIT-1:0] yaz_veri;
   logic                 unused_pixel;

`ifdef HISTOGRAM_CDF_EN
   logic [SAYAC_BIT-1:0] toplam_q;
   logic [SAYAC_BIT:0]   kum_genis;
   logic                 kum_tasma;
   logic [SAYAC_BIT-1:0] kum_toplam;
`endif

   assign pixel_bin    = pixel_i[PIXEL_BIT-1 -: BIN_BIT];
   assign unused_pixel = ^pixel_i;
   assign kabul        = (durum_q == StTopla) && etkin_i && !temizle_i;

   // S0: read the bin, or take S1's pending value when S1 targets the same bin, since
   // S1's write lands on the same edge that S0's result is registered.
   always_comb begin
      rmw_adres = s0_bin_q;
`ifdef HISTOGRAM_CDF_EN
      if (durum_q == StKumulatif) begin
         rmw_adres = adres_q[BIN_BIT-1:0];
      end
`endif
      rmw_okunan = bellek_q[rmw_adres];
      s0_eski    = (s1_gecerli_q && (s1_bin_q == s0_bin_q)) ? s1_deger_q : rmw_okunan;
      s0_doygun  = (s0_eski == SayacMax);
      s0_yeni    = s0_doygun ? s0_eski : s0_eski + 1'b1;
   end

`ifdef HISTOGRAM_CDF_EN
   always_comb begin
      kum_genis  = {1'b0, toplam_q} + {1'b0, rmw_okunan};
      kum_tasma  = kum_genis[SAYAC_BIT];
      kum_toplam = kum_tasma ? SayacMax : kum_genis[SAYAC_BIT-1:0];
   end
`endif

   // Single RAM write port; the clear, cumulative and RMW writers never overlap because
   // the pipeline is flushed on entry to clearing and drained before the cumulative pass.
   always_comb begin
      yaz       = 1'b0;
      yaz_adres = s1_bin_q;
      yaz_veri  = s1_deger_q;
      if (durum_q == StTemizle) begin
         yaz       = 1'b1;
         yaz_adres = adres_q[BIN_BIT-1:0];
         yaz_veri  = '0;
`ifdef HISTOGRAM_CDF_EN
      end else if ((durum_q == StKumulatif) && !adres_q[BIN_BIT]) begin
         yaz       = 1'b1;
         yaz_adres = adres_q[BIN_BIT-1:0];
         yaz_veri  = kum_toplam;
`endif
      end else if (s1_gecerli_q) begin
         yaz = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (yaz) begin
         bellek_q[yaz_adres] <= yaz_veri;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i || temizle_i) begin
         durum_q       <= StTemizle;
         adres_q       <= '0;
         psay_q        <= '0;
         bosalt_q      <= '0;
         s0_gecerli_q  <= 1'b0;
         s1_gecerli_q  <= 1'b0;
         mesgul_o      <= 1'b1;
         hazir_o       <= 1'b0;
         oku_gecerli_o <= 1'b0;
         tasma_o       <= 1'b0;
         if (!rstn_i) begin
            s0_bin_q   <= '0;
            s1_bin_q   <= '0;
            s1_deger_q <= '0;
            oku_veri_o <= '0;
         end
`ifdef HISTOGRAM_CDF_EN
         toplam_q <= '0;
`endif
      end else begin
         s0_gecerli_q <= kabul;
         if (kabul) begin
            s0_bin_q <= pixel_bin;
         end
         s1_gecerli_q <= s0_gecerli_q;
         if (s0_gecerli_q) begin
            s1_bin_q   <= s0_bin_q;
            s1_deger_q <= s0_yeni;
            if (s0_doygun) begin
               tasma_o <= 1'b1;
            end
         end

         oku_gecerli_o <= oku_i && (durum_q == StBitti);
         if (oku_i && (durum_q == StBitti)) begin
            oku_veri_o <= bellek_q[oku_adres_i];
         end

         unique case (durum_q)
            StTemizle: begin
               if (&adres_q[BIN_BIT-1:0]) begin
                  durum_q  <= StTopla;
                  mesgul_o <= 1'b0;
                  adres_q  <= '0;
                  psay_q   <= '0;
               end else begin
                  adres_q <= adres_q + 1'b1;
               end
            end
            StTopla: begin
               if (kabul) begin
                  psay_q <= psay_q + 1'b1;
                  if (psay_q == SonPiksel) begin
                     durum_q  <= StBosalt;
                     bosalt_q <= '0;
                  end
               end
            end
            StBosalt: begin
               // Lets the last pixel pass S0 and S1 and land in RAM before moving on.
               if (bosalt_q == 2'd2) begin
`ifdef HISTOGRAM_CDF_EN
                  durum_q  <= StKumulatif;
                  mesgul_o <= 1'b1;
                  adres_q  <= '0;
                  toplam_q <= '0;
`else
                  durum_q <= StBitti;
                  hazir_o <= 1'b1;
`endif
               end else begin
                  bosalt_q <= bosalt_q + 1'b1;
               end
            end
`ifdef HISTOGRAM_CDF_EN
            StKumulatif: begin
               if (adres_q[BIN_BIT]) begin
                  durum_q  <= StBitti;
                  mesgul_o <= 1'b0;
                  hazir_o  <= 1'b1;
               end else begin
                  toplam_q <= kum_toplam;
                  adres_q  <= adres_q + 1'b1;
                  if (kum_tasma) begin
                     tasma_o <= 1'b1;
                  end
               end
            end
`endif
            StBitti: begin
            end
            default: begin
               durum_q <= StTemizle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_histogram_hesaplayici.sv
module tb_histogram_hesaplayici;

   localparam int Kp     = 7680;
   localparam int Nbin   = 256;
   localparam int MaxAna = (1 << 17) - 1;
   localparam int KpK    = 20;
   localparam int MaxK   = 15;
   localparam int Sinir  = 3000;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn, etkin, temizle, oku;
   logic [7:0]  pixel, oku_adres;
   logic        mesgul, hazir, oku_gecerli, tasma;
   logic [16:0] oku_veri;

   logic        rstn_k, etkin_k, temizle_k, oku_k;
   logic [7:0]  pixel_k, oku_adres_k;
   logic        mesgul_k, hazir_k, oku_gecerli_k, tasma_k;
   logic [3:0]  oku_veri_k;

   histogram_hesaplayici #(
      .PIXEL_BIT(8), .BIN_BIT(8), .SAYAC_BIT(17), .KARE_PIKSEL(Kp)
   ) u_dut (
      .clk_i(clk), .rstn_i(rstn), .etkin_i(etkin), .pixel_i(pixel), .temizle_i(temizle),
      .mesgul_o(mesgul), .hazir_o(hazir), .oku_i(oku), .oku_adres_i(oku_adres),
      .oku_gecerli_o(oku_gecerli), .oku_veri_o(oku_veri), .tasma_o(tasma)
   );

   histogram_hesaplayici #(
      .PIXEL_BIT(8), .BIN_BIT(8), .SAYAC_BIT(4), .KARE_PIKSEL(KpK)
   ) u_kucuk (
      .clk_i(clk), .rstn_i(rstn_k), .etkin_i(etkin_k), .pixel_i(pixel_k),
      .temizle_i(temizle_k), .mesgul_o(mesgul_k), .hazir_o(hazir_k), .oku_i(oku_k),
      .oku_adres_i(oku_adres_k), .oku_gecerli_o(oku_gecerli_k), .oku_veri_o(oku_veri_k),
      .tasma_o(tasma_k)
   );

   int         n_chk = 0;
   int         n_fail = 0;
   int         ref_cnt [Nbin];
   int         ref_k [Nbin];
   logic       got_v [Nbin];
   int         got_d [Nbin];
   int         gec_hata;
   logic [7:0] px_q [$];

   // Reference model: histogram of the first frame-size pixels, saturating, optionally
   // turned into a saturating cumulative sum.
   function automatic int beklenen(input int sayim [Nbin], input int k, input int maxv);
      int t = 0;
`ifdef HISTOGRAM_CDF_EN
      for (int j = 0; j <= k; j++) begin
         t += (sayim[j] > maxv) ? maxv : sayim[j];
         if (t > maxv) t = maxv;
      end
`else
      t = (sayim[k] > maxv) ? maxv : sayim[k];
`endif
      return t;
   endfunction

   function automatic logic beklenen_tasma(input int sayim [Nbin], input int maxv);
      int t = 0;
      logic f = 1'b0;
      for (int j = 0; j < Nbin; j++) begin
         if (sayim[j] > maxv) f = 1'b1;
         t += sayim[j];
      end
`ifdef HISTOGRAM_CDF_EN
      if (t > maxv) f = 1'b1;
`endif
      return f;
   endfunction

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_hesapla();
      for (int j = 0; j < Nbin; j++) ref_cnt[j] = 0;
      for (int i = 0; i < px_q.size() && i < Kp; i++) ref_cnt[px_q[i]]++;
   endtask

   task automatic besle(input bit bosluk, input bit rastgele_oku);
      for (int i = 0; i < px_q.size(); i++) begin
         if (bosluk) begin
            while ($urandom_range(99) < 30) begin
               etkin = 1'b0;
               pixel = 8'($urandom);
               oku = rastgele_oku && (i < Kp) && ($urandom_range(1) == 1);
               oku_adres = 8'($urandom);
               cyc();
               if (oku_gecerli !== 1'b0) gec_hata++;
            end
         end
         etkin = 1'b1;
         pixel = px_q[i];
         oku = rastgele_oku && (i < Kp) && ($urandom_range(1) == 1);
         oku_adres = 8'($urandom);
         cyc();
         if (oku_gecerli !== 1'b0) gec_hata++;
      end
      etkin = 1'b0;
      oku = 1'b0;
   endtask

   task automatic bekle_hazir(output int n);
      n = 0;
      while (hazir !== 1'b1 && n < Sinir) begin
         cyc();
         n++;
      end
   endtask

   task automatic bekle_bos(input bit surekli_etkin, output int n);
      n = 0;
      etkin = surekli_etkin;
      pixel = 8'h40;
      while (mesgul !== 1'b0 && n < Sinir) begin
         cyc();
         n++;
      end
      etkin = 1'b0;
   endtask

   task automatic temizle_ve_bekle(output bit ok);
      int n;
      temizle = 1'b1;
      cyc();
      temizle = 1'b0;
      bekle_bos(1'b0, n);
      ok = (n < Sinir);
   endtask

   task automatic oku_hepsi();
      for (int k = 0; k < Nbin; k++) begin
         oku = 1'b1;
         oku_adres = 8'(k);
         cyc();
         got_v[k] = oku_gecerli;
         got_d[k] = int'(oku_veri);
      end
      oku = 1'b0;
   endtask

   task automatic oku_kucuk(input int adr, output logic v, output int d);
      oku_k = 1'b1;
      oku_adres_k = 8'(adr);
      cyc();
      v = oku_gecerli_k;
      d = int'(oku_veri_k);
      oku_k = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      rstn = 1'b0; rstn_k = 1'b0;
      cyc();
      cyc();
      n_chk++;
      if ({mesgul, hazir, oku_gecerli, tasma} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_flags got=%b want=1000", {mesgul, hazir, oku_gecerli, tasma});
      end
      n_chk++;
      if (oku_veri !== 17'd0) begin
         n_fail++;
         $display("FAIL reset_veri got=%0d want=0", oku_veri);
      end
      n_chk++;
      if ({mesgul_k, hazir_k, oku_gecerli_k, tasma_k} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_flags_k got=%b want=1000",
                  {mesgul_k, hazir_k, oku_gecerli_k, tasma_k});
      end
      rstn = 1'b1; rstn_k = 1'b1;
      n = 0;
      while (mesgul !== 1'b0 && n < Sinir) begin
         cyc();
         n++;
      end
      n_chk++;
      if (n !== Nbin) begin
         n_fail++;
         $display("FAIL clear_cycles got=%0d want=%0d", n, Nbin);
      end
      n_chk++;
      if (mesgul_k !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_k got=%b want=0", mesgul_k);
      end
   endtask

   task automatic test_tek_deger();
      int n, lat_bek;
      bit ok;
      px_q.delete();
      repeat (Kp) px_q.push_back(8'h05);
      model_hesapla();
      besle(1'b0, 1'b0);
      bekle_hazir(n);
`ifdef HISTOGRAM_CDF_EN
      lat_bek = 3 + Nbin + 1;
`else
      lat_bek = 3;
`endif
      n_chk++;
      if (n !== lat_bek) begin
         n_fail++;
         $display("FAIL hazir_latency got=%0d want=%0d", n, lat_bek);
      end
      n_chk++;
      if (tasma !== beklenen_tasma(ref_cnt, MaxAna)) begin
         n_fail++;
         $display("FAIL tek_tasma got=%b want=%b", tasma, beklenen_tasma(ref_cnt, MaxAna));
      end
      oku_hepsi();
      for (int k = 0; k < Nbin; k++) begin
         n_chk++;
         if (got_v[k] !== 1'b1 || got_d[k] !== beklenen(ref_cnt, k, MaxAna)) begin
            n_fail++;
            $display("FAIL tek_bin%0d got=%b/%0d want=1/%0d", k, got_v[k], got_d[k],
                     beklenen(ref_cnt, k, MaxAna));
         end
      end
      cyc();
      n_chk++;
      if (oku_gecerli !== 1'b0 || int'(oku_veri) !== beklenen(ref_cnt, Nbin - 1, MaxAna)) begin
         n_fail++;
         $display("FAIL veri_hold got=%b/%0d want=0/%0d", oku_gecerli, oku_veri,
                  beklenen(ref_cnt, Nbin - 1, MaxAna));
      end
      temizle = 1'b1; oku = 1'b1; oku_adres = 8'h05;
      cyc();
      temizle = 1'b0; oku = 1'b0;
      n_chk++;
      if ({hazir, mesgul, oku_gecerli} !== 3'b010) begin
         n_fail++;
         $display("FAIL temizle_oku got=%b want=010", {hazir, mesgul, oku_gecerli});
      end
      bekle_bos(1'b0, n);
      ok = (n < Sinir);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL tek_clear_timeout got=%0d want<%0d", n, Sinir);
      end
   endtask

   task automatic test_forwarding();
      int n;
      etkin = 1'b1; pixel = 8'h30; temizle = 1'b1;
      cyc();
      temizle = 1'b0;
      bekle_bos(1'b1, n);
      n_chk++;
      if (n >= Sinir) begin
         n_fail++;
         $display("FAIL fwd_clear_timeout got=%0d want<%0d", n, Sinir);
      end
      px_q.delete();
      for (int r = 0; r < Kp / 5; r++) begin
         px_q.push_back(8'h10); px_q.push_back(8'h10); px_q.push_back(8'h10);
         px_q.push_back(8'h11); px_q.push_back(8'h10);
      end
      model_hesapla();
      besle(1'b0, 1'b0);
      bekle_hazir(n);
      n_chk++;
      if (hazir !== 1'b1) begin
         n_fail++;
         $display("FAIL fwd_hazir got=%b want=1", hazir);
      end
      oku_hepsi();
      for (int k = 0; k < Nbin; k++) begin
         n_chk++;
         if (got_v[k] !== 1'b1 || got_d[k] !== beklenen(ref_cnt, k, MaxAna)) begin
            n_fail++;
            $display("FAIL fwd_bin%0d got=%b/%0d want=1/%0d", k, got_v[k], got_d[k],
                     beklenen(ref_cnt, k, MaxAna));
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int n;
      bit ok;
      temizle_ve_bekle(ok);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL mid_clear_timeout got=0 want=1");
      end
      px_q.delete();
      repeat (1000) px_q.push_back(8'hFF);
      besle(1'b0, 1'b0);
      rstn = 1'b0;
      cyc();
      cyc();
      rstn = 1'b1;
      n_chk++;
      if ({mesgul, hazir, tasma} !== 3'b100) begin
         n_fail++;
         $display("FAIL mid_reset got=%b want=100", {mesgul, hazir, tasma});
      end
      bekle_bos(1'b0, n);
      px_q.delete();
      repeat (Kp) px_q.push_back(8'h00);
      model_hesapla();
      besle(1'b0, 1'b0);
      bekle_hazir(n);
      n_chk++;
      if (hazir !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_hazir got=%b want=1", hazir);
      end
      oku_hepsi();
      for (int k = 0; k < Nbin; k++) begin
         n_chk++;
         if (got_v[k] !== 1'b1 || got_d[k] !== beklenen(ref_cnt, k, MaxAna)) begin
            n_fail++;
            $display("FAIL mid_bin%0d got=%b/%0d want=1/%0d", k, got_v[k], got_d[k],
                     beklenen(ref_cnt, k, MaxAna));
         end
      end
   endtask

   task automatic test_random();
      int n, adr;
      bit ok, istek;
      temizle_ve_bekle(ok);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL rnd_clear_timeout got=0 want=1");
      end
      px_q.delete();
      repeat (Kp + 4) px_q.push_back(8'($urandom));
      model_hesapla();
      gec_hata = 0;
      besle(1'b1, 1'b1);
      n_chk++;
      if (gec_hata !== 0) begin
         n_fail++;
         $display("FAIL early_read got=%0d want=0", gec_hata);
      end
      bekle_hazir(n);
      n_chk++;
      if (hazir !== 1'b1) begin
         n_fail++;
         $display("FAIL rnd_hazir got=%b want=1", hazir);
      end
      for (int i = 0; i < 64; i++) begin
         istek = ($urandom_range(3) != 0);
         adr = $urandom_range(Nbin - 1);
         oku = istek;
         oku_adres = 8'(adr);
         cyc();
         n_chk++;
         if (istek && (oku_gecerli !== 1'b1 ||
                       int'(oku_veri) !== beklenen(ref_cnt, adr, MaxAna))) begin
            n_fail++;
            $display("FAIL rnd_read%0d got=%b/%0d want=1/%0d", adr, oku_gecerli, oku_veri,
                     beklenen(ref_cnt, adr, MaxAna));
         end else if (!istek && oku_gecerli !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_idle got=%b want=0", oku_gecerli);
         end
      end
      oku = 1'b0;
      oku_hepsi();
      for (int k = 0; k < Nbin; k++) begin
         n_chk++;
         if (got_v[k] !== 1'b1 || got_d[k] !== beklenen(ref_cnt, k, MaxAna)) begin
            n_fail++;
            $display("FAIL rnd_bin%0d got=%b/%0d want=1/%0d", k, got_v[k], got_d[k],
                     beklenen(ref_cnt, k, MaxAna));
         end
      end
   endtask

   task automatic test_ramp();
      int n;
      bit ok;
      temizle_ve_bekle(ok);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL ramp_clear_timeout got=0 want=1");
      end
      px_q.delete();
      for (int i = 0; i < Kp; i++) px_q.push_back(8'(i % Nbin));
      model_hesapla();
      besle(1'b0, 1'b0);
      bekle_hazir(n);
      oku_hepsi();
      for (int k = 0; k < Nbin; k++) begin
         n_chk++;
         if (got_v[k] !== 1'b1 || got_d[k] !== beklenen(ref_cnt, k, MaxAna)) begin
            n_fail++;
            $display("FAIL ramp_bin%0d got=%b/%0d want=1/%0d", k, got_v[k], got_d[k],
                     beklenen(ref_cnt, k, MaxAna));
         end
      end
   endtask

   task automatic test_doyma();
      int n, d;
      logic v;
      int adr_list [3] = '{7, 8, 9};
      for (int j = 0; j < Nbin; j++) ref_k[j] = 0;
      for (int i = 0; i < KpK; i++) begin
         etkin_k = 1'b1; pixel_k = 8'h07;
         ref_k[7]++;
         cyc();
      end
      etkin_k = 1'b0;
      n = 0;
      while (hazir_k !== 1'b1 && n < Sinir) begin
         cyc();
         n++;
      end
      n_chk++;
      if (tasma_k !== beklenen_tasma(ref_k, MaxK)) begin
         n_fail++;
         $display("FAIL sat_tasma got=%b want=%b", tasma_k, beklenen_tasma(ref_k, MaxK));
      end
      oku_kucuk(7, v, d);
      n_chk++;
      if (v !== 1'b1 || d !== beklenen(ref_k, 7, MaxK)) begin
         n_fail++;
         $display("FAIL sat_bin7 got=%b/%0d want=1/%0d", v, d, beklenen(ref_k, 7, MaxK));
      end
      oku_kucuk(6, v, d);
      n_chk++;
      if (v !== 1'b1 || d !== beklenen(ref_k, 6, MaxK)) begin
         n_fail++;
         $display("FAIL sat_bin6 got=%b/%0d want=1/%0d", v, d, beklenen(ref_k, 6, MaxK));
      end
      temizle_k = 1'b1;
      cyc();
      temizle_k = 1'b0;
      n_chk++;
      if ({tasma_k, mesgul_k, hazir_k} !== 3'b010) begin
         n_fail++;
         $display("FAIL sat_clear got=%b want=010", {tasma_k, mesgul_k, hazir_k});
      end
      n = 0;
      while (mesgul_k !== 1'b0 && n < Sinir) begin
         cyc();
         n++;
      end
      for (int j = 0; j < Nbin; j++) ref_k[j] = 0;
      for (int i = 0; i < KpK; i++) begin
         etkin_k = 1'b1;
         pixel_k = (i < KpK / 2) ? 8'h08 : 8'h09;
         ref_k[pixel_k]++;
         cyc();
      end
      etkin_k = 1'b0;
      n = 0;
      while (hazir_k !== 1'b1 && n < Sinir) begin
         cyc();
         n++;
      end
      n_chk++;
      if (tasma_k !== beklenen_tasma(ref_k, MaxK)) begin
         n_fail++;
         $display("FAIL sat2_tasma got=%b want=%b", tasma_k, beklenen_tasma(ref_k, MaxK));
      end
      foreach (adr_list[i]) begin
         oku_kucuk(adr_list[i], v, d);
         n_chk++;
         if (v !== 1'b1 || d !== beklenen(ref_k, adr_list[i], MaxK)) begin
            n_fail++;
            $display("FAIL sat2_bin%0d got=%b/%0d want=1/%0d", adr_list[i], v, d,
                     beklenen(ref_k, adr_list[i], MaxK));
         end
      end
   endtask

   initial begin
      rstn = 1'b0; etkin = 1'b0; temizle = 1'b0; oku = 1'b0; pixel = '0; oku_adres = '0;
      rstn_k = 1'b0; etkin_k = 1'b0; temizle_k = 1'b0; oku_k = 1'b0;
      pixel_k = '0; oku_adres_k = '0;
      @(negedge clk);
      test_reset();
      test_tek_deger();
      test_forwarding();
      test_reset_mid_frame();
      test_random();
      test_ramp();
      test_doyma();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
